// File: rtl/muldiv_sequencer.sv
// Control sequencer for the HI/LO multiply/divide unit: launches the unit, waits for completion,
// writes HI/LO and signals done. Optional WAIT watchdog enabled by defining MULDIV_TIMEOUT_EN.
module muldiv_sequencer (
    input  logic       clk,
    input  logic       reset_in,
    input  logic       start,
    input  logic [1:0] op,
    input  logic       divisor_zero,
    input  logic       unit_done,
    output logic       busy,
    output logic       done,
    output logic       mult_control,
    output logic       DivOp,
    output logic       DivmOp,
    output logic       HI_reg_w,
    output logic       LO_reg_w,
    output logic       Mux_HILO,
    output logic       div_zero_exc,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_WRITE,
        ST_DONE,
        ST_EXC,
        ST_TIMEOUT
    } state_t;

    typedef enum logic [1:0] {
        OP_MULT = 2'b00,
        OP_DIV  = 2'b01,
        OP_DIVM = 2'b10,
        OP_RSVD = 2'b11
    } op_t;

    state_t state, state_next;
    op_t    op_q, op_next;

    logic busy_d, done_d, mult_d, div_d, divm_d, hilo_w_d, mux_d, dze_d;
    logic hilo_w;

`ifdef MULDIV_TIMEOUT_EN
    logic [5:0] wd_cnt;
    logic       timeout_d;
`endif

    // NOTE: every variable gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        op_next    = op_q;
        case (state)
            ST_IDLE: begin
                if (start && op != OP_RSVD) begin
                    if (op != OP_MULT && divisor_zero) begin
                        state_next = ST_EXC;
                    end else begin
                        state_next = ST_LAUNCH;
                        op_next    = op_t'(op);
                    end
                end
            end
            ST_LAUNCH: state_next = ST_WAIT;
            ST_WAIT: begin
                if (unit_done) begin
                    state_next = ST_WRITE;
`ifdef MULDIV_TIMEOUT_EN
                end else if (wd_cnt == 6'd63) begin
                    state_next = ST_TIMEOUT;
`endif
                end
            end
            ST_WRITE:   state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            ST_EXC:     state_next = ST_IDLE;
            ST_TIMEOUT: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with the state.
    always_comb begin
        busy_d   = (state_next != ST_IDLE);
        mult_d   = (state_next == ST_LAUNCH) && (op_next == OP_MULT);
        div_d    = (state_next == ST_LAUNCH) && (op_next == OP_DIV);
        divm_d   = (state_next == ST_LAUNCH) && (op_next == OP_DIVM);
        hilo_w_d = (state_next == ST_WRITE);
        mux_d    = (state_next inside {ST_LAUNCH, ST_WAIT, ST_WRITE}) && (op_next != OP_MULT);
        done_d   = (state_next inside {ST_DONE, ST_EXC, ST_TIMEOUT});
        dze_d    = (state_next == ST_EXC);
`ifdef MULDIV_TIMEOUT_EN
        timeout_d = (state_next == ST_TIMEOUT);
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            state        <= ST_IDLE;
            op_q         <= OP_MULT;
            busy         <= 1'b0;
            done         <= 1'b0;
            mult_control <= 1'b0;
            DivOp        <= 1'b0;
            DivmOp       <= 1'b0;
            hilo_w       <= 1'b0;
            Mux_HILO     <= 1'b0;
            div_zero_exc <= 1'b0;
        end else begin
            state        <= state_next;
            op_q         <= op_next;
            busy         <= busy_d;
            done         <= done_d;
            mult_control <= mult_d;
            DivOp        <= div_d;
            DivmOp       <= divm_d;
            hilo_w       <= hilo_w_d;
            Mux_HILO     <= mux_d;
            div_zero_exc <= dze_d;
        end
    end

    assign HI_reg_w = hilo_w;
    assign LO_reg_w = hilo_w;

`ifdef MULDIV_TIMEOUT_EN
    // Counter sits at zero outside WAIT, so it reads zero on the first WAIT cycle.
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            wd_cnt      <= 6'd0;
            timeout_err <= 1'b0;
        end else begin
            wd_cnt      <= (state == ST_WAIT) ? wd_cnt + 6'd1 : 6'd0;
            timeout_err <= timeout_d;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus predicts output beats from the protocol rules,
// a negedge monitor compares every pulse the DUT presents.
module tb_muldiv_sequencer;

    logic       clk = 1'b0;
    logic       reset_in, start, divisor_zero, unit_done;
    logic [1:0] op;
    logic       busy, done, mult_control, DivOp, DivmOp, HI_reg_w, LO_reg_w, Mux_HILO;
    logic       div_zero_exc, timeout_err;

    muldiv_sequencer dut (
        .clk         (clk),
        .reset_in    (reset_in),
        .start       (start),
        .op          (op),
        .divisor_zero(divisor_zero),
        .unit_done   (unit_done),
        .busy        (busy),
        .done        (done),
        .mult_control(mult_control),
        .DivOp       (DivOp),
        .DivmOp      (DivmOp),
        .HI_reg_w    (HI_reg_w),
        .LO_reg_w    (LO_reg_w),
        .Mux_HILO    (Mux_HILO),
        .div_zero_exc(div_zero_exc),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Output vector bits: busy done mult div divm hi lo mux dze to
    localparam logic [9:0] B_BUSY = 10'b1000000000;
    localparam logic [9:0] B_DONE = 10'b0100000000;
    localparam logic [9:0] B_MULT = 10'b0010000000;
    localparam logic [9:0] B_DIV  = 10'b0001000000;
    localparam logic [9:0] B_DIVM = 10'b0000100000;
    localparam logic [9:0] B_HILO = 10'b0000011000;
    localparam logic [9:0] B_MUX  = 10'b0000000100;
    localparam logic [9:0] B_DZE  = 10'b0000000010;
    localparam logic [9:0] B_TO   = 10'b0000000001;
    localparam logic [9:0] PULSES = 10'b0111111011;
    localparam logic [9:0] M_ALL  = 10'b1111111111;
    localparam logic [9:0] M_NOMX = 10'b1111111011;
    localparam logic [9:0] M_NOBM = 10'b0111111011;

    typedef struct {
        int         edge_no;
        logic [9:0] val;
        logic [9:0] mask;
    } beat_t;

    beat_t exp_q[$];
    int    n_vec  = 0;
    int    n_fail = 0;

    function automatic logic [9:0] outs_now();
        return {busy, done, mult_control, DivOp, DivmOp, HI_reg_w, LO_reg_w, Mux_HILO,
                div_zero_exc, timeout_err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic void push(input int e, input logic [9:0] v, input logic [9:0] m);
        beat_t b;
        b.edge_no = e;
        b.val     = v;
        b.mask    = m;
        exp_q.push_back(b);
    endfunction

    // Monitor: every cycle that shows a pulse is matched against the next predicted beat.
    always @(negedge clk) begin
        logic [9:0] o;
        beat_t      b;
        o = outs_now();
        if ((o & PULSES) != 10'd0) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: edge %0d outputs %b, required no pulse", edge_n, o);
            end else begin
                b = exp_q.pop_front();
                if (b.edge_no != edge_n || ((o ^ b.val) & b.mask) != 10'd0) begin
                    n_fail++;
                    $display("FAIL beat: edge %0d outputs %b, required edge %0d outputs %b mask %b",
                             edge_n, o, b.edge_no, b.val, b.mask);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request. d = edges spent in WAIT before unit_done is seen (>= 1).
    task automatic do_op(input logic [1:0] o, input logic dz, input int d, input bit hold,
                         input bit noise);
        int         e;
        logic [9:0] mux;
        tick();
        start = 1'b1;
        op = o;
        divisor_zero = dz;
        e = edge_n + 1;
        mux = (o != 2'b00) ? B_MUX : 10'd0;
        if (o == 2'b11) begin
            tick();
            start = 1'b0;
            op = 2'($urandom);
        end else if (o != 2'b00 && dz) begin
            push(e, B_BUSY | B_DONE | B_DZE, M_NOMX);
            tick();
            start = hold;
            op = 2'($urandom);
            tick();
            start = 1'b0;
        end else begin
            push(e, B_BUSY | mux | (o == 2'b00 ? B_MULT : (o == 2'b01 ? B_DIV : B_DIVM)), M_ALL);
            push(e + 1 + d, B_BUSY | B_HILO | mux, M_ALL);
            push(e + 2 + d, B_BUSY | B_DONE, M_NOMX);
            tick();
            start = hold;
            op = 2'($urandom);
            divisor_zero = 1'($urandom);
            unit_done = noise;
            for (int k = e + 2; k <= e + 1 + d; k++) begin
                tick();
                unit_done = (k == e + 1 + d);
            end
            tick();
            unit_done = 1'($urandom);
            start = hold;
            tick();
            start = 1'b0;
            unit_done = 1'b0;
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL sim_timeout: run did not complete");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int e;
        reset_in = 1'b0;
        start = 1'b0;
        op = 2'b00;
        divisor_zero = 1'b0;
        unit_done = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'(outs_now()), 32'd0);
        tick();
        reset_in = 1'b1;
        unit_done = 1'b0;

        // Reserved op: nothing may move for 10 cycles.
        do_op(2'b11, 1'b0, 1, 1'b0, 1'b0);
        repeat (10) begin
            @(negedge clk);
            check("reserved_idle", 32'(outs_now()), 32'd0);
        end

        do_op(2'b00, 1'b0, 32, 1'b0, 1'b0);
        do_op(2'b01, 1'b1, 1, 1'b0, 1'b0);
        do_op(2'b10, 1'b1, 1, 1'b1, 1'b0);
        do_op(2'b00, 1'b1, 5, 1'b0, 1'b1);
        do_op(2'b10, 1'b0, 5, 1'b1, 1'b1);
        do_op(2'b01, 1'b0, 1, 1'b0, 1'b1);

        // Reset in the middle of a DIV wait; the later unit_done must not produce a write.
        tick();
        start = 1'b1;
        op = 2'b01;
        divisor_zero = 1'b0;
        e = edge_n + 1;
        push(e, B_BUSY | B_DIV | B_MUX, M_ALL);
        tick();
        start = 1'b0;
        repeat (3) tick();
        reset_in = 1'b0;
        tick();
        reset_in = 1'b1;
        unit_done = 1'b1;
        @(negedge clk);
        check("reset_mid_wait", 32'(outs_now()), 32'd0);
        repeat (4) begin
            tick();
            @(negedge clk);
            check("post_reset_idle", 32'(outs_now()), 32'd0);
        end
        tick();
        unit_done = 1'b0;

        // Watchdog: MULT whose unit never finishes.
        tick();
        start = 1'b1;
        op = 2'b00;
        e = edge_n + 1;
        push(e, B_BUSY | B_MULT, M_ALL);
`ifdef MULDIV_TIMEOUT_EN
        push(e + 65, B_DONE | B_TO, M_NOBM);
`endif
        tick();
        start = 1'b0;
`ifdef MULDIV_TIMEOUT_EN
        repeat (70) tick();
        @(negedge clk);
        check("watchdog_idle", 32'(busy), 32'd0);
`else
        repeat (100) tick();
        @(negedge clk);
        check("watchdog_busy_held", 32'(busy), 32'd1);
        reset_in = 1'b0;
        tick();
        reset_in = 1'b1;
        @(negedge clk);
        check("watchdog_reset", 32'(outs_now()), 32'd0);
`endif

        for (int i = 0; i < 40; i++) begin
            do_op(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                  int'($urandom_range(1, 40)), 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) tick();
        end

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        repeat (5) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have port: clk  input  1  system clock; all state changes on rising edge.
REQ-002 The block SHALL have port: reset_in  input  1  synchronous, active-low reset.
REQ-003 The block SHALL have port: start  input  1  request from control unit; sampled only in IDLE.
REQ-004 The block SHALL have port: op  input  2  operation; 00 MULT, 01 DIV, 10 DIVM, 11 reserved.
REQ-005 The block SHALL have port: divisor_zero  input  1  B register equals zero; sampled with start.
REQ-006 The block SHALL have port: unit_done  input  1  completion level/pulse from mult/div unit.
REQ-007 The block SHALL have port: busy  output  1  operation in progress.
REQ-008 The block SHALL have port: done  output  1  one-cycle completion pulse to control unit.
REQ-009 The block SHALL have port: mult_control  output  1  one-cycle start pulse to multiplier.
REQ-010 The block SHALL have port: DivOp  output  1  one-cycle start pulse to divider, DIV.
REQ-011 The block SHALL have port: DivmOp  output  1  one-cycle start pulse to divider, DIVM.
REQ-012 The block SHALL have port: HI_reg_w, LO_reg_w  output  1 each  HI/LO write enables.
REQ-013 The block SHALL have port: Mux_HILO  output  1  HI/LO source; 0 multiplier, 1 divider.
REQ-014 The block SHALL have port: div_zero_exc  output  1  one-cycle divide-by-zero exception pulse.
REQ-015 The block SHALL have port: timeout_err  output  1  one-cycle watchdog pulse (see Configuration).

Function
REQ-016 The FSM SHALL have states IDLE, LAUNCH, WAIT, WRITE, DONE, EXC, all outputs registered.
REQ-017 In IDLE with start=1 and op in {01,10} and divisor_zero=1, next state SHALL be EXC.
REQ-018 In IDLE with start=1 and op in {00,01,10} otherwise, next state SHALL be LAUNCH; op latched.
REQ-019 start with op=11 SHALL be ignored: stay IDLE, no output change.
REQ-020 LAUNCH SHALL last exactly one cycle asserting exactly one of mult_control/DivOp/DivmOp per latched op, then WAIT.
REQ-021 WAIT SHALL hold until unit_done=1, then WRITE; unit_done during LAUNCH SHALL be ignored.
REQ-022 WRITE SHALL last one cycle with HI_reg_w=LO_reg_w=1, then DONE.
REQ-023 DONE SHALL last one cycle with done=1, then IDLE.
REQ-024 EXC SHALL last one cycle with div_zero_exc=1, done=1, no HI/LO write, no unit start, then IDLE.
REQ-025 busy SHALL be 1 in LAUNCH, WAIT, WRITE, DONE, EXC; 0 in IDLE.
REQ-026 Mux_HILO SHALL be set from latched op in LAUNCH and held stable through WRITE.
REQ-027 Latency: start at edge t -> start pulse at t+1; unit_done seen at edge u -> HI/LO write at u+1, done at u+2.
REQ-028 start outside IDLE (including DONE cycle) SHALL be ignored; no queueing.
REQ-029 unit_done in IDLE, WRITE, DONE or EXC SHALL be ignored.

Reset
REQ-030 reset_in=0 at any rising edge SHALL force IDLE, clear latched op and watchdog counter, regardless of state.
REQ-031 During and after reset all outputs SHALL be 0: busy, done, mult_control, DivOp, DivmOp, HI_reg_w, LO_reg_w, Mux_HILO, div_zero_exc, timeout_err.
REQ-032 Reset mid-operation SHALL suppress any pending HI/LO write and done pulse.

Configuration
REQ-033 Macro MULDIV_TIMEOUT_EN defined: 6-bit counter cleared on WAIT entry, increments per WAIT cycle; at count 63 without unit_done, FSM SHALL pulse timeout_err and done for one cycle, no HI/LO write, then IDLE.
REQ-034 Macro MULDIV_TIMEOUT_EN undefined: WAIT SHALL be unbounded, no counter, timeout_err tied to 0.

Verification
REQ-035 MULT: start=1, op=00; unit_done at 33rd cycle after start -> mult_control one pulse at t+1, HI/LO write one cycle, Mux_HILO=0, done one cycle later.
REQ-036 DIV by zero: start=1, op=01, divisor_zero=1 -> next cycle div_zero_exc=1, done=1, DivOp never asserted, HI_reg_w=LO_reg_w=0.
REQ-037 DIVM: start=1, op=10, divisor_zero=0, unit_done after 5 cycles -> DivmOp one pulse, Mux_HILO=1 through WRITE, done pulse; start held high during busy not re-accepted.
REQ-038 Reset mid-WAIT: reset_in=0 for one edge during DIV WAIT, unit_done asserted afterwards -> all outputs 0, state IDLE, no HI/LO write.
REQ-039 Watchdog (macro defined): MULT with unit_done never asserted -> timeout_err and done pulse 64 cycles after WAIT entry; macro undefined -> busy stays 1 indefinitely.
REQ-040 Reserved op: start=1, op=11 -> busy stays 0, no pulses for 10 cycles.
